// File: rtl/sigma_delta_bitstream_decoder_if.sv
// Bitstream input and PCM sample-output handshake for sigma_delta_bitstream_decoder.
// master: bit source / sample consumer side; slave: the decoder.
interface sigma_delta_bitstream_decoder_if #(
   parameter int unsigned OUT_WIDTH = 16
);
   logic                 bit_in;
   logic                 bit_en;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 overrun;

   modport master (
      output bit_in, bit_en, out_ready,
      input  out_data, out_valid, overrun
   );

   modport slave (
      input  bit_in, bit_en, out_ready,
      output out_data, out_valid, overrun
   );
endinterface

// File: rtl/sigma_delta_bitstream_decoder.sv
// Sinc3 CIC decimator turning a 1-bit sigma-delta stream into unsigned PCM samples.
// Optional `SIGMA_DELTA_DEC_OVERRUN_CNT_EN adds a saturating 8-bit overrun_cnt port.
module sigma_delta_bitstream_decoder #(
   parameter int unsigned DEC_LOG2  = 6,
   parameter int unsigned OUT_WIDTH = 16
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            clr,
   sigma_delta_bitstream_decoder_if.slave  bus
`ifdef SIGMA_DELTA_DEC_OVERRUN_CNT_EN
   ,
   output logic [7:0]                      overrun_cnt
`endif
);

   localparam int unsigned FS    = 3 * DEC_LOG2;
   localparam int unsigned W     = FS + 1;
   localparam int unsigned SHIFT = FS - OUT_WIDTH;

   typedef enum logic [1:0] {
      ST_SETTLE0,
      ST_SETTLE1,
      ST_RUN
   } settle_state_t;

   settle_state_t state, state_nx;

   logic [W-1:0]          i1, i2, i3;
   logic [W-1:0]          i1_nx, i2_nx, i3_nx;
   logic [DEC_LOG2-1:0]   phase;
   logic                  decim_strobe;

   logic [W-1:0]          x, x_d1, c1_d, c2_d;
   logic [W-1:0]          c1, c2, c3;
   logic [W-1:0]          f_reg;
   logic                  f_valid;
   logic                  sample_ok;

   logic [FS-1:0]         s_val;
   logic [OUT_WIDTH-1:0]  sample;
   logic [OUT_WIDTH-1:0]  out_data_q;
   logic                  out_valid_q;
   logic                  overrun_q;
   logic                  ovr_event;

   // Chained next values let the accepted bit reach i3 on the same edge.
   always_comb begin
      i1_nx = i1 + W'(bus.bit_in);
      i2_nx = i2 + i1_nx;
      i3_nx = i3 + i2_nx;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         i1           <= '0;
         i2           <= '0;
         i3           <= '0;
         phase        <= '0;
         x            <= '0;
         decim_strobe <= 1'b0;
      end else if (clr) begin
         i1           <= '0;
         i2           <= '0;
         i3           <= '0;
         phase        <= '0;
         x            <= '0;
         decim_strobe <= 1'b0;
      end else begin
         decim_strobe <= 1'b0;
         if (bus.bit_en) begin
            i1    <= i1_nx;
            i2    <= i2_nx;
            i3    <= i3_nx;
            phase <= phase + 1'b1;
            if (phase == '1) begin
               x            <= i3_nx;
               decim_strobe <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      c1 = x - x_d1;
      c2 = c1 - c1_d;
      c3 = c2 - c2_d;
   end

   // Settling: the first two decimated samples lack a full 3R-bit history.
   always_comb begin
      state_nx  = state;
      sample_ok = 1'b0;
      if (decim_strobe) begin
         unique case (state)
            ST_SETTLE0: state_nx = ST_SETTLE1;
            ST_SETTLE1: state_nx = ST_RUN;
            default:    sample_ok = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_SETTLE0;
         x_d1    <= '0;
         c1_d    <= '0;
         c2_d    <= '0;
         f_reg   <= '0;
         f_valid <= 1'b0;
      end else if (clr) begin
         state   <= ST_SETTLE0;
         x_d1    <= '0;
         c1_d    <= '0;
         c2_d    <= '0;
         f_reg   <= '0;
         f_valid <= 1'b0;
      end else begin
         state   <= state_nx;
         f_valid <= 1'b0;
         if (decim_strobe) begin
            x_d1    <= x;
            c1_d    <= c1;
            c2_d    <= c2;
            f_reg   <= c3;
            f_valid <= sample_ok;
         end
      end
   end

   // F tops out at exactly 2^FS (only bit W-1 set), which saturates to all-ones.
   always_comb begin
      s_val  = f_reg[W-1] ? '1 : f_reg[FS-1:0];
      sample = OUT_WIDTH'(s_val >> SHIFT);
   end

   assign ovr_event = f_valid && out_valid_q && !bus.out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else if (clr) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         overrun_q <= ovr_event;
         if (f_valid) begin
            out_data_q  <= sample;
            out_valid_q <= 1'b1;
         end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.overrun   = overrun_q;

`ifdef SIGMA_DELTA_DEC_OVERRUN_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overrun_cnt <= '0;
      end else if (clr) begin
         overrun_cnt <= '0;
      end else if (ovr_event && (overrun_cnt != 8'hFF)) begin
         overrun_cnt <= overrun_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: doc/sigma_delta_bitstream_decoder.md
Name: sigma_delta_bitstream_decoder

Overview:
- Decodes a 1-bit sigma-delta stream into multibit PCM samples using a 3rd-order CIC (sinc3) decimator with power-of-two decimation ratio.
- Sits on the receive side of our 1st-order sigma-delta DAC links: loopback checking, and the digital back end of sigma-delta ADC front ends.
- Scaling is chosen so that a stream whose ones-density is d/2^OUT_WIDTH decodes back to d.

Parameters:
- DEC_LOG2, 6, log2 of decimation ratio R (R = 2^DEC_LOG2); legal range 2..10.
- OUT_WIDTH, 16, output sample width; must satisfy OUT_WIDTH <= 3*DEC_LOG2.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear; restarts the filter exactly as reset does.
- bit_in  input  1  sigma-delta bit; 1 maps to +1, 0 maps to 0.
- bit_en  input  1  bit_in is accepted on a clk edge where bit_en=1.
- out_data  output  OUT_WIDTH  decoded sample, unsigned.
- out_valid  output  1  out_data holds an unconsumed sample.
- out_ready  input  1  consumer accepts the sample on a clk edge where out_valid=1 and out_ready=1.
- overrun  output  1  one-cycle pulse: an unconsumed sample was overwritten.

Behaviour:
- Internal width W = 3*DEC_LOG2+1. The three integrators and three combs are W-bit, with modular wrap-around; wrap is required and is not an error.
- Integrators: on each accepted bit, I1 += bit_in, I2 += I1_new, I3 += I2_new. Chained new values are used so the accepted bit reaches I3 in the same edge.
- Phase counter (DEC_LOG2 bits) counts accepted bits. On the accepted bit that makes the count reach R:
  - I3_new is captured into the comb input register.
  - The counter wraps to 0.
  - decim_strobe is raised for one cycle.
- Comb stage, registered, cycle after the strobe: C1 = x - x_d1, C2 = C1 - C1_d, C3 = C2 - C2_d. The delays update only on strobes. The result is full-scale value F, range 0..2^(3*DEC_LOG2).
- Output mapping: S = min(F, 2^(3*DEC_LOG2)-1), then out_data = S >> (3*DEC_LOG2-OUT_WIDTH). The all-ones stream saturates to the all-ones output.
- Latency: out_valid rises 2 clk cycles after the edge that accepts the period-completing bit.
- Settling: the samples from the first 2 decimation periods after reset or clr are discarded internally. The first out_valid corresponds to the end of accepted bit 3R.
- Handshake: out_data is stable while out_valid=1 and out_ready=0. Cases on an edge:
  - Consumer accepts, no new sample: out_valid falls.
  - New sample arrives while the current one is accepted: the new sample is loaded, out_valid stays 1, no overrun.
  - New sample arrives while out_valid=1 and out_ready=0: the new sample overwrites and overrun pulses 1 cycle.
- bit_en low: no state changes except the output handshake. Gaps in bit_en do not disturb the result.
- Reset (async) or clr (sync, highest priority) clears:
  - integrators, combs, comb delays, phase counter, settle counter;
  - out_data=0, out_valid=0, overrun=0.
  - A mid-period reset discards the partial period; settling restarts.

Optional Feature:
- Macro: SIGMA_DELTA_DEC_OVERRUN_CNT_EN.
- When defined:
  - Adds output port overrun_cnt, 8 bits, saturating count of overrun events.
  - Cleared by reset_n/clr; holds at 255.
- When undefined:
  - The port and the counter do not exist.
  - The overrun pulse behaviour is identical either way.

Test Plan:
- All scenarios use defaults (R=64), out_ready=1 and bit_en=1 unless stated.
- All-zero stream -> first out_valid 2 clk after accepted bit 192; every sample 0x0000; overrun never set.
- All-ones stream -> every sample 0xFFFF (saturated, F=2^18).
- Alternating 1,0 stream -> every sample 0x8000. Repeat with bit_en=1 only every 3rd cycle -> identical samples at one third the rate.
- Stream from a bit-accurate 1st-order DAC model with d=0x4000, then d=0xC123 -> settled samples within ±1 LSB of 0x4000, then of 0xC123 (third sample after the step).
- Backpressure: hold out_ready=0 across two decimation periods -> first sample held stable, overrun pulses once, out_data becomes the second sample. Raising out_ready drops out_valid next edge. With macro defined, overrun_cnt=1.
- Assert reset_n mid-period (bit 100 of period 5) -> outputs 0 immediately. After release, the first out_valid occurs only after a further 192 accepted bits. clr at the same point behaves identically on the next edge.
